// File: rtl/add_round_key_stream_if.sv
// Handshake bundle for the streaming AddRoundKey stage: data, key and output channels.
interface add_round_key_stream_if #(
   parameter int DATA_W     = 128,
   parameter int KEY_DEPTH  = 4,
   parameter int NUM_ROUNDS = 10
);
   localparam int RW = $clog2(NUM_ROUNDS + 1);
   localparam int LW = $clog2(KEY_DEPTH + 1);

   logic              data_valid_in;
   logic              data_ready_out;
   logic [DATA_W-1:0] data_in;
   logic              bypass_in;
   logic              key_valid_in;
   logic              key_ready_out;
   logic [DATA_W-1:0] round_key;
   logic              valid_out;
   logic              ready_in;
   logic [DATA_W-1:0] data_out;
   logic [RW-1:0]     round_idx_out;
   logic              last_round_out;
   logic [LW-1:0]     key_level_out;

   modport master (
      output data_valid_in, data_in, bypass_in, key_valid_in, round_key, ready_in,
      input  data_ready_out, key_ready_out, valid_out, data_out, round_idx_out,
             last_round_out, key_level_out
   );

   modport slave (
      input  data_valid_in, data_in, bypass_in, key_valid_in, round_key, ready_in,
      output data_ready_out, key_ready_out, valid_out, data_out, round_idx_out,
             last_round_out, key_level_out
   );
endinterface

// File: rtl/add_round_key_stream.sv
// Streaming AddRoundKey: XORs each data beat with the head of a round-key FIFO,
// tagging outputs with a wrapping round index. Bypass beats pass through unkeyed.
module add_round_key_stream #(
   parameter int DATA_W     = 128,
   parameter int KEY_DEPTH  = 4,
   parameter int NUM_ROUNDS = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_in,
   add_round_key_stream_if.slave bus
);
   localparam int RW = $clog2(NUM_ROUNDS + 1);
   localparam int LW = $clog2(KEY_DEPTH + 1);
   localparam int AW = $clog2(KEY_DEPTH);

   logic [DATA_W-1:0] key_mem_q [KEY_DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]     level_q, level_d;
   logic [RW-1:0]     round_q, round_d;
   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [RW-1:0]     idx_q, idx_d;
   logic              last_q, last_d;

   logic key_ready, data_ready, out_free, push, pop, accept;
   logic [DATA_W-1:0] head;

   assign head       = key_mem_q[rd_ptr_q];
   assign key_ready  = (level_q != LW'(KEY_DEPTH)) && !clear_in;
   assign out_free   = !valid_q || bus.ready_in;
   assign data_ready = out_free && (bus.bypass_in || level_q != '0) && !clear_in;
   assign push       = bus.key_valid_in && key_ready;
   assign accept     = bus.data_valid_in && data_ready;
   assign pop        = accept && !bus.bypass_in;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      round_d  = round_q;
      valid_d  = valid_q;
      data_d   = data_q;
      idx_d    = idx_q;
      last_d   = last_q;
      if (clear_in) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
         round_d  = '0;
         valid_d  = 1'b0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            round_d  = (round_q == RW'(NUM_ROUNDS)) ? '0 : round_q + RW'(1);
         end
         level_d = level_q + LW'(push) - LW'(pop);
         if (accept) begin
            valid_d = 1'b1;
            data_d  = bus.bypass_in ? bus.data_in : (bus.data_in ^ head);
            idx_d   = round_q;
            last_d  = !bus.bypass_in && (round_q == RW'(NUM_ROUNDS));
         end else if (bus.ready_in) begin
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         round_q  <= '0;
         valid_q  <= 1'b0;
         data_q   <= '0;
         idx_q    <= '0;
         last_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         round_q  <= round_d;
         valid_q  <= valid_d;
         data_q   <= data_d;
         idx_q    <= idx_d;
         last_q   <= last_d;
      end
   end

   // Key storage needs no reset: the level and pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push) key_mem_q[wr_ptr_q] <= bus.round_key;
   end

   assign bus.key_ready_out  = key_ready;
   assign bus.data_ready_out = data_ready;
   assign bus.valid_out      = valid_q;
   assign bus.data_out       = data_q;
   assign bus.round_idx_out  = idx_q;
   assign bus.last_round_out = last_q;
   assign bus.key_level_out  = level_q;
endmodule
